parking_timestamp: RTL

- Upstream stage of the parking time calculator.
- Keeps a free-running time base and a per-slot table of entry timestamps.
- On a vehicle exit, presents the matched pair time_in/time_out. The downstream subtractor produces the parking duration from this pair.
- Also reports occupancy, full status and request errors to the lot controller.

---
 rtl/parking_timestamp.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/parking_timestamp.sv
// Entry/exit timestamp stage for the parking time calculator: free-running time base,
// per-slot entry stamp table, occupancy tracking and registered exit pair output.
module parking_timestamp #(
    parameter int SLOTS    = 8,
    parameter int SLOT_W   = 3,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              car_in,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic              car_out,
    input  logic [SLOT_W-1:0] out_slot,
    output logic [7:0]        time_in,
    output logic [7:0]        time_out,
    output logic              pair_valid,
    output logic [SLOTS-1:0]  occupied,
    output logic [SLOT_W:0]   car_count,
    output logic              full,
    output logic              err
);

    localparam int                PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(1);
    localparam logic [SLOTS-1:0]  SLOT_ONE = SLOTS'(1);
    localparam logic [SLOT_W:0]   CNT_ONE  = (SLOT_W + 1)'(1);
    localparam logic [SLOT_W:0]   CNT_FULL = (SLOT_W + 1)'(SLOTS);

    logic [PS_W-1:0]  r_presc;
    logic [7:0]       r_time;
    logic [7:0]       r_stamp [SLOTS];
    logic [SLOTS-1:0] r_occ;
    logic [SLOT_W:0]  r_count;
    logic [7:0]       r_time_in;
    logic [7:0]       r_time_out;
    logic             r_pair_valid;
    logic             r_err;

    logic             w_presc_wrap;
    logic             w_same_slot;
    logic             w_in_ok;
    logic             w_out_ok;
    logic             w_err;
    logic [SLOTS-1:0] w_set_mask;
    logic [SLOTS-1:0] w_clr_mask;
    logic [SLOTS-1:0] w_occ_nxt;
    logic [SLOT_W:0]  w_count_nxt;

    assign w_presc_wrap = (r_presc == PS_LAST);

    // Prescaler and 8-bit wrapping time counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_time  <= 8'd0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_time  <= r_time + 8'd1;
        end else begin
            r_presc <= r_presc + PS_ONE;
        end
    end

    // Request qualification; a same-slot entry/exit pair is rejected as a whole.
    always_comb begin
        w_same_slot = 1'b0;
        w_in_ok     = 1'b0;
        w_out_ok    = 1'b0;
        if (car_in && car_out && (in_slot == out_slot)) begin
            w_same_slot = 1'b1;
        end else begin
            w_same_slot = 1'b0;
        end
        if (car_in && !r_occ[in_slot] && !w_same_slot) begin
            w_in_ok = 1'b1;
        end else begin
            w_in_ok = 1'b0;
        end
        if (car_out && r_occ[out_slot] && !w_same_slot) begin
            w_out_ok = 1'b1;
        end else begin
            w_out_ok = 1'b0;
        end
        w_err = (car_in && !w_in_ok) || (car_out && !w_out_ok);
    end

    // Next occupancy vector and car count.
    always_comb begin
        w_set_mask  = w_in_ok  ? (SLOT_ONE << in_slot)  : '0;
        w_clr_mask  = w_out_ok ? (SLOT_ONE << out_slot) : '0;
        w_occ_nxt   = (r_occ | w_set_mask) & ~w_clr_mask;
        w_count_nxt = r_count;
        case ({w_in_ok, w_out_ok})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Entry stamp table, written only on an accepted entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_stamp[i] <= 8'd0;
            end
        end else if (w_in_ok) begin
            r_stamp[in_slot] <= r_time;
        end
    end

    // Occupancy, count and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ        <= '0;
            r_count      <= '0;
            r_pair_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_occ        <= w_occ_nxt;
            r_count      <= w_count_nxt;
            r_pair_valid <= w_out_ok;
            r_err        <= w_err;
        end
    end

    // Exit pair; held between exits so the downstream subtractor sees stable operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time_in  <= 8'd0;
            r_time_out <= 8'd0;
        end else if (w_out_ok) begin
            r_time_in  <= r_stamp[out_slot];
            r_time_out <= r_time;
        end
    end

    assign time_in    = r_time_in;
    assign time_out   = r_time_out;
    assign pair_valid = r_pair_valid;
    assign occupied   = r_occ;
    assign car_count  = r_count;
    assign err        = r_err;
    assign full       = (r_count == CNT_FULL);

endmodule
